uram_port_arbiter: RTL and testbench

URAM_PORT_ARBITER -- requirements
Module: uram_port_arbiter

---
 rtl/uram_ctrl_pkg.sv | 22 ++
 rtl/uram_rd_tag_pipe.sv | 33 +++
 rtl/uram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_uram_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uram_ctrl_pkg.sv
// Shared types and constants for the URAM port-A arbiter.
package uram_ctrl_pkg;

  localparam int URAM_DATA_W    = 72;
  localparam int URAM_BWE_W     = 9;
  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } arb_state_e;

  // Out-of-range latencies are pulled into the supported window.
  function automatic int clamp_rd_latency(input int lat);
    if (lat < RD_LATENCY_MIN) return RD_LATENCY_MIN;
    if (lat > RD_LATENCY_MAX) return RD_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/uram_rd_tag_pipe.sv
// Read tag pipeline: carries {valid, requester id} from the handshake cycle
// to the cycle where URAM DOUT holds the matching word.
module uram_rd_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_id,
  output logic rsp0_valid,
  output logic rsp1_valid,
  output logic in_flight
);

  logic [DEPTH-1:0] tag_valid_reg;
  logic [DEPTH-1:0] tag_id_reg;

  // Shift tags one stage per cycle; reset drops every read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
    end else begin
      tag_valid_reg <= {tag_valid_reg[DEPTH-2:0], push};
      tag_id_reg    <= {tag_id_reg[DEPTH-2:0], push_id};
    end
  end

  assign rsp0_valid = tag_valid_reg[DEPTH-1] & ~tag_id_reg[DEPTH-1];
  assign rsp1_valid = tag_valid_reg[DEPTH-1] &  tag_id_reg[DEPTH-1];
  assign in_flight  = |tag_valid_reg;

endmodule

// File: rtl/uram_port_arbiter.sv
// Two-requester round-robin arbiter onto a single URAM port A, with idle
// sleep entry and a fixed wake-up delay before access resumes.
module uram_port_arbiter
  import uram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int RD_LATENCY  = 1,
  parameter int IDLE_SLEEP  = 64,
  parameter int WAKE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_we,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [URAM_DATA_W-1:0] req0_wdata,
  input  logic [URAM_BWE_W-1:0]  req0_bwe,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_we,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [URAM_DATA_W-1:0] req1_wdata,
  input  logic [URAM_BWE_W-1:0]  req1_bwe,
  output logic                   rsp0_valid,
  output logic [URAM_DATA_W-1:0] rsp0_rdata,
  output logic                   rsp1_valid,
  output logic [URAM_DATA_W-1:0] rsp1_rdata,
  output logic                   uram_en,
  output logic                   uram_rdb_wr,
  output logic                   uram_sleep,
  output logic [ADDR_W-1:0]      uram_addr,
  output logic [URAM_DATA_W-1:0] uram_din,
  output logic [URAM_BWE_W-1:0]  uram_bwe,
  input  logic [URAM_DATA_W-1:0] uram_dout
);

  localparam int LAT    = clamp_rd_latency(RD_LATENCY);
  localparam int IDLE_W = (IDLE_SLEEP > 0) ? $clog2(IDLE_SLEEP + 1) : 1;
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_SLEEP > 0) ? IDLE_SLEEP - 1 : 0);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

  arb_state_e        state_reg, state_next;
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic [WAKE_W-1:0] wake_cnt_reg;
  logic              last_id_reg;
  logic              is_active;
  logic              grant0, grant1;
  logic              hs, hs_id, idle_cycle, in_flight;
  logic              sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [URAM_DATA_W-1:0] sel_wdata;
  logic [URAM_BWE_W-1:0]  sel_bwe;
  logic                   rsp0_tag, rsp1_tag;

  // Round robin: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_id_reg);
    grant1 = req1_valid && (!req0_valid || !last_id_reg);
  end

  assign req0_ready = is_active && grant0;
  assign req1_ready = is_active && grant1;
  assign hs         = req0_ready || req1_ready;
  assign hs_id      = req1_ready;
  assign idle_cycle = (state_reg == ST_ACTIVE) && !hs && !in_flight;

  // Mux the winning request onto the port registers.
  always_comb begin
    sel_we    = hs_id ? req1_we    : req0_we;
    sel_addr  = hs_id ? req1_addr  : req0_addr;
    sel_wdata = hs_id ? req1_wdata : req0_wdata;
    sel_bwe   = hs_id ? req1_bwe   : req0_bwe;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_ACTIVE;
    else     state_reg <= state_next;
  end

  // Next state: sleep after enough quiet cycles, wake on any request.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACTIVE: if (IDLE_SLEEP > 0 && idle_cycle && idle_cnt_reg == IDLE_LAST) state_next = ST_SLEEP;
      ST_SLEEP:  if (req0_valid || req1_valid) state_next = (WAKE_CYCLES == 0) ? ST_ACTIVE : ST_WAKE;
      ST_WAKE:   if (wake_cnt_reg == WAKE_LAST) state_next = ST_ACTIVE;
      default:   state_next = ST_ACTIVE;
    endcase
  end

  // State-derived outputs; ready is held off while reset is asserted.
  always_comb begin
    is_active  = (state_reg == ST_ACTIVE) && !rst;
    uram_sleep = (state_reg == ST_SLEEP);
  end

  // Idle and wake counters plus the last-served pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_reg <= '0;
      wake_cnt_reg <= '0;
      last_id_reg  <= 1'b1;
    end else begin
      if (!idle_cycle)                 idle_cnt_reg <= '0;
      else if (idle_cnt_reg != IDLE_MAX) idle_cnt_reg <= idle_cnt_reg + 1'b1;
      if (state_reg == ST_WAKE) wake_cnt_reg <= wake_cnt_reg + 1'b1;
      else                      wake_cnt_reg <= '0;
      if (hs) last_id_reg <= hs_id;
    end
  end

  // Port A registers: enable pulses for one cycle, the rest hold between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uram_en     <= 1'b0;
      uram_rdb_wr <= 1'b0;
      uram_addr   <= '0;
      uram_din    <= '0;
      uram_bwe    <= '0;
    end else begin
      uram_en <= hs;
      if (hs) begin
        uram_rdb_wr <= sel_we;
        uram_addr   <= sel_addr;
        uram_din    <= sel_wdata;
        uram_bwe    <= sel_bwe;
      end
    end
  end

  uram_rd_tag_pipe #(.DEPTH(LAT + 1)) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push       (hs && !sel_we),
    .push_id    (hs_id),
    .rsp0_valid (rsp0_tag),
    .rsp1_valid (rsp1_tag),
    .in_flight  (in_flight)
  );

  assign rsp0_valid = rsp0_tag;
  assign rsp1_valid = rsp1_tag;
  assign rsp0_rdata = rsp0_tag ? uram_dout : '0;
  assign rsp1_rdata = rsp1_tag ? uram_dout : '0;

endmodule

// File: tb/tb_uram_port_arbiter.sv
// Bench for uram_port_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_uram_port_arbiter;

  localparam int AW    = 8;
  localparam int LAT   = 3;
  localparam int ISLP  = 4;
  localparam int WAKE  = 3;
  localparam int WORDS = 1 << AW;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic [71:0]   wdata;
    logic [8:0]    bwe;
  } req_t;

  typedef struct {
    int          due;
    bit          id;
    logic [71:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req0_addr, req1_addr, uram_addr;
  logic [71:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, uram_din, uram_dout;
  logic [8:0] req0_bwe, req1_bwe, uram_bwe;
  logic rsp0_valid, rsp1_valid, uram_en, uram_rdb_wr, uram_sleep;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uram_port_arbiter #(
    .ADDR_W(AW), .RD_LATENCY(LAT), .IDLE_SLEEP(ISLP), .WAKE_CYCLES(WAKE)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_bwe(req0_bwe),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_bwe(req1_bwe),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .uram_en(uram_en), .uram_rdb_wr(uram_rdb_wr), .uram_sleep(uram_sleep),
    .uram_addr(uram_addr), .uram_din(uram_din), .uram_bwe(uram_bwe),
    .uram_dout(uram_dout)
  );

  function automatic logic [71:0] init_word(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b, ~b, {7{b ^ 8'h5A}}};
  endfunction

  function automatic logic [71:0] merge(input logic [71:0] old, input logic [71:0] nw,
                                        input logic [8:0] be);
    logic [71:0] r;
    r = old;
    for (int b = 0; b < 9; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // URAM port A model with LAT-cycle read pipeline.
  logic [71:0] umem [WORDS];
  bit          uwr  [WORDS];
  logic [71:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (uram_en && uram_rdb_wr) begin
      umem[uram_addr] <= merge(uwr[uram_addr] ? umem[uram_addr] : init_word(int'(uram_addr)),
                               uram_din, uram_bwe);
      uwr[uram_addr]  <= 1'b1;
    end
    rd_pipe[0] <= (uram_en && !uram_rdb_wr)
                  ? (uwr[uram_addr] ? umem[uram_addr] : init_word(int'(uram_addr))) : 72'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign uram_dout = rd_pipe[LAT-1];

  // Reference model state.
  logic [71:0] exp_mem [WORDS];
  bit          exp_wr  [WORDS];
  rsp_t        rsp_q[$];
  bit          m_sleeping, m_last, m_en, m_wr;
  int          m_wake_left, m_idle, cyc;
  logic [AW-1:0] m_addr;
  logic [71:0]   m_din;
  logic [8:0]    m_bwe;

  function automatic logic [71:0] exp_word(input logic [AW-1:0] a);
    return exp_wr[a] ? exp_mem[a] : init_word(int'(a));
  endfunction

  function automatic req_t mk_idle();
    return '{valid: 1'b0, we: 1'b0, addr: '0, wdata: '0, bwe: '0};
  endfunction
  function automatic req_t mk_rd(input logic [AW-1:0] a);
    return '{valid: 1'b1, we: 1'b0, addr: a, wdata: '0, bwe: '0};
  endfunction
  function automatic req_t mk_wr(input logic [AW-1:0] a, input logic [71:0] d, input logic [8:0] be);
    return '{valid: 1'b1, we: 1'b1, addr: a, wdata: d, bwe: be};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_reset();
    rsp_q.delete();
    m_sleeping = 0; m_last = 1; m_en = 0; m_wr = 0;
    m_wake_left = 0; m_idle = 0;
    m_addr = '0; m_din = '0; m_bwe = '0;
  endtask

  task automatic drive(input req_t r0, input req_t r1);
    req0_valid = r0.valid; req0_we = r0.we; req0_addr = r0.addr;
    req0_wdata = r0.wdata; req0_bwe = r0.bwe;
    req1_valid = r1.valid; req1_we = r1.we; req1_addr = r1.addr;
    req1_wdata = r1.wdata; req1_bwe = r1.bwe;
  endtask

  // One clock cycle: drive, check every output against the model, advance the model.
  task automatic step(input req_t r0, input req_t r1);
    bit act, g0, g1, e0, e1, inflight, hs, gid;
    logic [71:0] ed;
    req_t rs;
    @(negedge clk);
    drive(r0, r1);
    #1;
    act = !m_sleeping && (m_wake_left == 0);
    g0  = act && r0.valid && (!r1.valid || m_last);
    g1  = act && r1.valid && (!r0.valid || !m_last);
    e0 = 0; e1 = 0; ed = '0;
    inflight = (rsp_q.size() != 0);
    if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
      e0 = !rsp_q[0].id; e1 = rsp_q[0].id; ed = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    chk("req0_ready", 72'(req0_ready), 72'(g0));
    chk("req1_ready", 72'(req1_ready), 72'(g1));
    chk("rsp0_valid", 72'(rsp0_valid), 72'(e0));
    chk("rsp1_valid", 72'(rsp1_valid), 72'(e1));
    if (e0) chk("rsp0_rdata", rsp0_rdata, ed);
    if (e1) chk("rsp1_rdata", rsp1_rdata, ed);
    chk("uram_en", 72'(uram_en), 72'(m_en));
    chk("uram_sleep", 72'(uram_sleep), 72'(m_sleeping));
    chk("uram_rdb_wr", 72'(uram_rdb_wr), 72'(m_wr));
    chk("uram_addr", 72'(uram_addr), 72'(m_addr));
    chk("uram_din", uram_din, m_din);
    chk("uram_bwe", 72'(uram_bwe), 72'(m_bwe));
    hs  = g0 || g1;
    gid = g1;
    rs  = g1 ? r1 : r0;
    m_en = hs;
    if (hs) begin
      m_last = gid; m_wr = rs.we; m_addr = rs.addr; m_din = rs.wdata; m_bwe = rs.bwe;
      if (rs.we) begin
        exp_mem[rs.addr] = merge(exp_word(rs.addr), rs.wdata, rs.bwe);
        exp_wr[rs.addr]  = 1'b1;
      end else begin
        rsp_q.push_back('{due: cyc + 1 + LAT, id: gid, data: exp_word(rs.addr)});
      end
    end
    if (act) begin
      if (hs || inflight) m_idle = 0;
      else                m_idle++;
      if (m_idle == ISLP) begin m_sleeping = 1; m_idle = 0; end
    end else if (m_sleeping) begin
      if (r0.valid || r1.valid) begin m_sleeping = 0; m_wake_left = WAKE; end
    end else begin
      m_wake_left--;
    end
    $display("cycle %0d: v=%b%b ready=%b%b en=%b sleep=%b rsp=%b%b", cyc,
             r0.valid, r1.valid, req0_ready, req1_ready, uram_en, uram_sleep, rsp0_valid, rsp1_valid);
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready0"}, 72'(req0_ready), 72'h0);
    chk({tag, "_ready1"}, 72'(req1_ready), 72'h0);
    chk({tag, "_rsp0"}, 72'(rsp0_valid), 72'h0);
    chk({tag, "_rsp1"}, 72'(rsp1_valid), 72'h0);
    chk({tag, "_rdata0"}, rsp0_rdata, 72'h0);
    chk({tag, "_rdata1"}, rsp1_rdata, 72'h0);
    chk({tag, "_en"}, 72'(uram_en), 72'h0);
    chk({tag, "_sleep"}, 72'(uram_sleep), 72'h0);
    chk({tag, "_rdb_wr"}, 72'(uram_rdb_wr), 72'h0);
    chk({tag, "_addr"}, 72'(uram_addr), 72'h0);
    chk({tag, "_din"}, uram_din, 72'h0);
    chk({tag, "_bwe"}, 72'(uram_bwe), 72'h0);
  endtask

  initial begin
    req_t ra, rb;
    int   busy;
    cyc = 0;
    model_reset();
    rst = 1'b1;
    drive(mk_rd(8'h10), mk_rd(8'h20));
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    @(posedge clk); #2 rst = 1'b0;

    // Both requesters read continuously: grants alternate 0,1,0,1...
    repeat (8) step(mk_rd(8'h10), mk_rd(8'h20));
    repeat (6) step(mk_idle(), mk_idle());

    // Full-width write then read-back on requester 0.
    step(mk_wr(8'hAB, 72'h12_3456_789A_BCDE_F012, 9'h1FF), mk_idle());
    step(mk_rd(8'hAB), mk_idle());
    repeat (6) step(mk_idle(), mk_idle());

    // Eight back-to-back reads from requester 1.
    for (int i = 0; i < 8; i++) step(mk_idle(), mk_rd(8'(8'h30 + i)));

    // Drain, fall asleep, then wake on a held request.
    repeat (12) step(mk_idle(), mk_idle());
    repeat (6) step(mk_rd(8'hAB), mk_idle());
    repeat (4) step(mk_idle(), mk_idle());

    // Random traffic with alternating busy and quiet phases.
    for (int i = 0; i < 400; i++) begin
      busy = ((i / 40) % 2 == 0) ? 3 : 10;
      ra = mk_idle(); rb = mk_idle();
      ra.valid = ($urandom_range(0, busy) < 3) ? ($urandom_range(0, busy - 1) == 0 || busy == 3) : 1'b0;
      rb.valid = ($urandom_range(0, busy) < 3) ? 1'b1 : 1'b0;
      ra.we = 1'($urandom); rb.we = 1'($urandom);
      ra.addr = 8'($urandom_range(0, 15)); rb.addr = 8'($urandom_range(0, 15));
      ra.wdata = {8'($urandom), 32'($urandom), 32'($urandom)};
      rb.wdata = {8'($urandom), 32'($urandom), 32'($urandom)};
      ra.bwe = 9'($urandom); rb.bwe = 9'($urandom);
      step(ra, rb);
    end

    // Reset with reads in flight: everything clears, nothing comes back.
    repeat (10) step(mk_rd(8'h10), mk_rd(8'h20));
    @(negedge clk);
    rst = 1'b1;
    #1 chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    repeat (3) step(mk_rd(8'h10), mk_rd(8'h20));
    repeat (8) step(mk_idle(), mk_idle());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
